// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the burst pattern generator: mode codes, FSM state encoding and
// a helper deciding which modes cannot run from an all-zero seed.
package pattern_gen_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // LFSR and walking-one would lock up at zero, so their seed is forced non-zero.
    function automatic logic needs_nonzero_seed(input logic [1:0] mode);
        return (mode == MODE_LFSR) || (mode == MODE_WALK);
    endfunction

endpackage

// File: rtl/pattern_next.sv
// Combinational successor function for the pattern generator: given the current beat and
// the selected mode, produces the following beat.
module pattern_next
    import pattern_gen_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        unique case (mode_i)
            MODE_INC:   d_o = d_i + WIDTH'(1);
            MODE_LFSR:  d_o = (d_i >> 1) ^ (d_i[0] ? TAPS : '0);
            MODE_WALK:  d_o = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
            MODE_CONST: d_o = d_i;
            default:    d_o = d_i;
        endcase
    end

endmodule

// File: rtl/pattern_gen.sv
// Burst test-data source: emits burst_len beats of a selected pattern over a valid/ready
// stream, then pulses done for one cycle.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      CNT_W = 16,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [CNT_W-1:0] burst_len_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] next_data;
    logic [WIDTH-1:0] seed_eff;
    logic             rem_is_one;

    pattern_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_pattern_next (
        .mode_i (mode_q),
        .d_i    (data_q),
        .d_o    (next_data)
    );

    assign seed_eff   = (seed_i == '0 && needs_nonzero_seed(mode_i))
                        ? {{(WIDTH-1){1'b0}}, 1'b1} : seed_i;
    assign rem_is_one = (rem_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mode_d = mode_i;
                        if (burst_len_i != '0) begin
                            state_d = ST_RUN;
                            data_d  = seed_eff;
                            rem_d   = burst_len_i;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (out_ready_i) begin
                        rem_d = rem_q - CNT_W'(1);
                        // The final beat stays on data_out so the last value is observable.
                        if (rem_is_one) begin
                            state_d = ST_DONE;
                        end else begin
                            data_d = next_data;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_INC;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    assign out_valid_o = (state_q == ST_RUN);
    assign out_last_o  = out_valid_o && rem_is_one;
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign data_out_o  = data_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: scoreboarded bursts in each mode plus abort, zero
// length and mid-burst reset scenarios.
module tb_pattern_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] burst_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic [7:0] exp_stall[$];
    logic [7:0] obs_d[$];
    logic       obs_l[$];
    logic [7:0] obs_stall[$];

    pattern_gen #(
        .WIDTH (8),
        .CNT_W (16),
        .TAPS  (8'hB8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .abort_i     (abort),
        .mode_i      (mode),
        .seed_i      (seed),
        .burst_len_i (burst_len),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_out_o  (data_out),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_model(input logic [7:0] d);
        return (d >> 1) ^ (d[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] inc_model(input logic [7:0] d);
        return d + 8'd1;
    endfunction

    function automatic logic [7:0] walk_model(input logic [7:0] d);
        return {d[6:0], d[7]};
    endfunction

    task automatic clear_queues();
        exp_d.delete(); exp_l.delete(); exp_stall.delete();
        obs_d.delete(); obs_l.delete(); obs_stall.delete();
    endtask

    // Pulses start for one clock; afterwards the latched inputs are scrambled.
    task automatic start_burst(input logic [1:0] m, input logic [7:0] s, input logic [15:0] len);
        mode = m; seed = s; burst_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'd3; seed = 8'h33; burst_len = 16'd7;
    endtask

    // Collects transferred beats and stalled data until done appears or the budget expires.
    task automatic capture(input int max_cyc, input bit toggle, output int done_cyc);
        done_cyc = -1;
        for (int c = 0; c < max_cyc; c++) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (out_valid && out_ready) begin
                obs_d.push_back(data_out);
                obs_l.push_back(out_last);
            end else if (out_valid) begin
                obs_stall.push_back(data_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, data_out, out_last, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b busy=%b done=%b, expected all 0",
                     out_valid, data_out, out_last, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_inc();
        int done_cyc;
        logic [7:0] d, ed, od;
        logic el, ol;
        clear_queues();
        d = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            exp_d.push_back(d); exp_l.push_back(i == 3); d = inc_model(d);
        end
        start_burst(2'd0, 8'hFE, 16'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL inc_busy: got %b, expected 1", busy);
        end
        capture(20, 1'b0, done_cyc);
        checks++;
        if (done_cyc !== 4) begin
            errors++; $display("FAIL inc_done_cycle: got %0d, expected 4", done_cyc);
        end
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front(); el = exp_l.pop_front(); checks++;
            if (obs_d.size() == 0) begin
                errors++; $display("FAIL inc_beat: got none, expected %h last=%b", ed, el);
            end else begin
                od = obs_d.pop_front(); ol = obs_l.pop_front();
                if ({od, ol} !== {ed, el}) begin
                    errors++;
                    $display("FAIL inc_beat: got %h last=%b, expected %h last=%b", od, ol, ed, el);
                end
            end
        end
        checks++;
        if (obs_d.size() != 0) begin
            errors++; $display("FAIL inc_extra_beats: got %0d, expected 0", obs_d.size());
        end
        @(negedge clk);
    endtask

    task automatic test_lfsr();
        int done_cyc;
        logic [7:0] d, ed, od;
        logic el, ol;
        for (int run = 0; run < 2; run++) begin
            int len;
            len = (run == 0) ? 3 : 256;
            clear_queues();
            d = 8'h01;
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(d); exp_l.push_back(i == len - 1); d = lfsr_model(d);
            end
            start_burst(2'd1, 8'h00, 16'(len));
            capture(len + 20, 1'b0, done_cyc);
            checks++;
            if (done_cyc !== len) begin
                errors++; $display("FAIL lfsr_done_cycle: got %0d, expected %0d", done_cyc, len);
            end
            for (int i = 0; i < len; i++) begin
                ed = exp_d.pop_front(); el = exp_l.pop_front(); checks++;
                if (obs_d.size() == 0) begin
                    errors++; $display("FAIL lfsr_beat %0d: got none, expected %h", i, ed);
                end else begin
                    od = obs_d.pop_front(); ol = obs_l.pop_front();
                    if ({od, ol} !== {ed, el}) begin
                        errors++;
                        $display("FAIL lfsr_beat %0d: got %h last=%b, expected %h last=%b",
                                 i, od, ol, ed, el);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_walk_backpressure();
        int done_cyc;
        logic [7:0] ed, od;
        logic el, ol;
        clear_queues();
        exp_d.push_back(8'h80); exp_l.push_back(1'b0);
        exp_d.push_back(walk_model(8'h80)); exp_l.push_back(1'b0);
        exp_d.push_back(walk_model(walk_model(8'h80))); exp_l.push_back(1'b1);
        exp_stall.push_back(8'h01); exp_stall.push_back(8'h02);
        start_burst(2'd2, 8'h80, 16'd3);
        capture(20, 1'b1, done_cyc);
        checks++;
        if (done_cyc !== 5) begin
            errors++; $display("FAIL walk_done_cycle: got %0d, expected 5", done_cyc);
        end
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front(); el = exp_l.pop_front(); checks++;
            if (obs_d.size() == 0) begin
                errors++; $display("FAIL walk_beat: got none, expected %h", ed);
            end else begin
                od = obs_d.pop_front(); ol = obs_l.pop_front();
                if ({od, ol} !== {ed, el}) begin
                    errors++;
                    $display("FAIL walk_beat: got %h last=%b, expected %h last=%b", od, ol, ed, el);
                end
            end
        end
        while (exp_stall.size() > 0) begin
            ed = exp_stall.pop_front(); checks++;
            if (obs_stall.size() == 0) begin
                errors++; $display("FAIL walk_stall_hold: got none, expected %h", ed);
            end else begin
                od = obs_stall.pop_front();
                if (od !== ed) begin
                    errors++; $display("FAIL walk_stall_hold: got %h, expected %h", od, ed);
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        start_burst(2'd0, 8'hAA, 16'd0);
        checks++;
        if ({done, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b valid=%b busy=%b, expected 1 0 0",
                     done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL zero_len_after: got done=%b valid=%b busy=%b, expected 0 0 0",
                     done, out_valid, busy);
        end
    endtask

    task automatic test_abort();
        int seen_done;
        out_ready = 1'b1;
        start_burst(2'd0, 8'h10, 16'd10);
        // A second start while running must not reload the seed.
        start = 1'b1; seed = 8'h77; mode = 2'd1; burst_len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({out_valid, data_out} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL abort_start_ignored: got valid=%b data=%h, expected 1 11", out_valid, data_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({out_valid, busy, done, data_out} !== {3'b000, 8'h11}) begin
            errors++;
            $display("FAIL abort_stop: got valid=%b busy=%b done=%b data=%h, expected 0 0 0 11",
                     out_valid, busy, done, data_out);
        end
        seen_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d active cycles, expected 0", seen_done);
        end
    endtask

    task automatic test_reset_midburst();
        int done_cyc;
        logic [7:0] ed, od;
        logic el, ol;
        out_ready = 1'b0;
        start_burst(2'd2, 8'h01, 16'd5);
        checks++;
        if ({out_valid, data_out} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL midreset_first_beat: got valid=%b data=%h, expected 1 01", out_valid, data_out);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({out_valid, data_out, out_last, busy, done} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b data=%h last=%b busy=%b done=%b, expected all 0",
                     out_valid, data_out, out_last, busy, done);
        end
        clear_queues();
        exp_d.push_back(8'h5A); exp_l.push_back(1'b0);
        exp_d.push_back(8'h5A); exp_l.push_back(1'b1);
        out_ready = 1'b1;
        start_burst(2'd3, 8'h5A, 16'd2);
        capture(20, 1'b0, done_cyc);
        checks++;
        if (done_cyc !== 2) begin
            errors++; $display("FAIL restart_done_cycle: got %0d, expected 2", done_cyc);
        end
        while (exp_d.size() > 0) begin
            ed = exp_d.pop_front(); el = exp_l.pop_front(); checks++;
            if (obs_d.size() == 0) begin
                errors++; $display("FAIL restart_beat: got none, expected %h", ed);
            end else begin
                od = obs_d.pop_front(); ol = obs_l.pop_front();
                if ({od, ol} !== {ed, el}) begin
                    errors++;
                    $display("FAIL restart_beat: got %h last=%b, expected %h last=%b", od, ol, ed, el);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; seed = 8'h00;
        burst_len = 16'd0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_inc();
        test_lfsr();
        test_walk_backpressure();
        test_zero_len();
        test_abort();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
